// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-outstanding memory bus.
// Each access runs IDLE -> BUSY -> RESP; BUSY aborts with an error after TIMEOUT cycles without S_RDY.
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] A_M,
    output logic [31:0] D_M,
    output logic [3:0]  BE_M,
    output logic        E_M,
    output logic        S_REQ,
    input  logic [31:0] O_M,
    input  logic        S_RDY,
    output logic        stall,
    output logic        busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic               last;
    logic               we_q;
    logic [CNT_W-1:0]   cnt;
    logic               grant_m1;
    logic               done;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;

    // A tie goes to whichever master was not served last; a lone requester always wins.
    always_comb begin
        grant_m1  = m1_req & (~m0_req | ~last);
        done      = S_RDY | (cnt == CNT_W'(TIMEOUT - 1));
        rsp_rdata = (S_RDY && !we_q) ? O_M : 32'h0;
        rsp_err   = ~S_RDY;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            we_q     <= 1'b0;
            cnt      <= '0;
            A_M      <= 32'h0;
            D_M      <= 32'h0;
            BE_M     <= 4'h0;
            E_M      <= 1'b0;
            S_REQ    <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state <= BUSY;
                        last  <= grant_m1;
                        cnt   <= '0;
                        S_REQ <= 1'b1;
                        A_M   <= grant_m1 ? m1_addr  : m0_addr;
                        D_M   <= grant_m1 ? m1_wdata : m0_wdata;
                        BE_M  <= grant_m1 ? m1_be    : m0_be;
                        E_M   <= grant_m1 ? m1_we    : m0_we;
                        we_q  <= grant_m1 ? m1_we    : m0_we;
                    end
                end
                BUSY: begin
                    if (done) begin
                        // S_RDY on the final counted cycle still wins over the timeout.
                        state <= RESP;
                        S_REQ <= 1'b0;
                        E_M   <= 1'b0;
                        A_M   <= 32'h0;
                        D_M   <= 32'h0;
                        BE_M  <= 4'h0;
                        if (last) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= rsp_rdata;
                            m1_err   <= rsp_err;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= rsp_rdata;
                            m0_err   <= rsp_err;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single loads/stores, round-robin ties, timeout, and reset abort.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, S_RDY;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, O_M;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_err, m1_ack, m1_err, E_M, S_REQ, stall, busy;
    logic [31:0] m0_rdata, m1_rdata, A_M, D_M;
    logic [3:0]  BE_M;

    int n_cmp = 0;
    int n_fail = 0;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_we(m0_we),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_we(m1_we),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .A_M(A_M), .D_M(D_M), .BE_M(BE_M), .E_M(E_M), .S_REQ(S_REQ),
        .O_M(O_M), .S_RDY(S_RDY), .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
        S_RDY = 0; O_M = 0;
        tick(); tick();
        n_cmp++;
        if ({S_REQ, busy, m0_ack, m1_ack, E_M, stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {S_REQ, busy, m0_ack, m1_ack, E_M, stall});
        end
        n_cmp++;
        if ({A_M, D_M, BE_M, m0_rdata, m1_rdata, m0_err, m1_err} !== '0) begin
            n_fail++; $display("FAIL reset_data: A_M=%h D_M=%h BE_M=%h r0=%h r1=%h want 0", A_M, D_M, BE_M, m0_rdata, m1_rdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_m0_load();
        m0_req = 1; m0_addr = 32'h0000_3004; m0_we = 0; m0_be = 4'hF; m0_wdata = 32'h0;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_pre: got %b want 1", stall); end
        tick();
        n_cmp++;
        if ({busy, S_REQ, E_M, stall} !== 4'b1101 || A_M !== 32'h0000_3004 || BE_M !== 4'hF) begin
            n_fail++; $display("FAIL load_busy: busy/sreq/em/stall=%b A_M=%h BE_M=%h want 1101 00003004 f", {busy, S_REQ, E_M, stall}, A_M, BE_M);
        end
        S_RDY = 1; O_M = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if ({m0_ack, m1_ack, m0_err, stall, S_REQ} !== 5'b10000 || m0_rdata !== 32'hDEAD_BEEF || A_M !== 32'h0) begin
            n_fail++; $display("FAIL load_ack: flags=%b rdata=%h A_M=%h want 10000 deadbeef 0", {m0_ack, m1_ack, m0_err, stall, S_REQ}, m0_rdata, A_M);
        end
        m0_req = 0; S_RDY = 0; O_M = 32'h0;
        tick();
        n_cmp++;
        if (m0_ack !== 1'b0 || busy !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL load_after: ack=%b busy=%b rdata=%h want 0 0 deadbeef", m0_ack, busy, m0_rdata);
        end
    endtask

    task automatic test_m1_store();
        m1_req = 1; m1_addr = 32'h0000_7F10; m1_be = 4'b0011; m1_wdata = 32'h1234_1234; m1_we = 1;
        S_RDY = 0; O_M = 32'hAAAA_5555;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({S_REQ, E_M} !== 2'b11 || BE_M !== 4'b0011 || A_M !== 32'h0000_7F10 || D_M !== 32'h1234_1234) begin
                n_fail++; $display("FAIL store_busy%0d: sreq/em=%b BE_M=%b A_M=%h D_M=%h want 11 0011 00007f10 12341234", i, {S_REQ, E_M}, BE_M, A_M, D_M);
            end
            if (i == 3) S_RDY = 1;
            tick();
        end
        n_cmp++;
        if ({m1_ack, m0_ack, m1_err, S_REQ} !== 4'b1000 || m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL store_ack: flags=%b rdata=%h want 1000 0", {m1_ack, m0_ack, m1_err, S_REQ}, m1_rdata);
        end
        n_cmp++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL hold_m0_rdata: got %h want deadbeef", m0_rdata);
        end
        m1_req = 0; m1_we = 0; S_RDY = 0;
        tick();
        n_cmp++;
        if (m1_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL store_after: ack=%b busy=%b want 0 0", m1_ack, busy);
        end
    endtask

    task automatic test_timeout();
        int nbusy = 0;
        m0_req = 1; m0_addr = 32'h0000_0100; m0_we = 0; S_RDY = 0; O_M = 32'hFFFF_FFFF;
        tick();
        while (S_REQ === 1'b1 && nbusy < 40) begin
            nbusy++;
            tick();
        end
        n_cmp++;
        if (nbusy != 15) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 15", nbusy); end
        n_cmp++;
        if ({m0_ack, m0_err} !== 2'b11 || m0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL timeout_resp: ack/err=%b rdata=%h want 11 0", {m0_ack, m0_err}, m0_rdata);
        end
        m0_req = 0;
        tick();
    endtask

    task automatic test_rdy_at_limit();
        m0_req = 1; m0_addr = 32'h0000_0200; m0_we = 0; S_RDY = 0; O_M = 32'hCAFE_F00D;
        tick();
        for (int i = 0; i < 14; i++) tick();
        n_cmp++;
        if (S_REQ !== 1'b1 || m0_ack !== 1'b0) begin
            n_fail++; $display("FAIL limit_still_busy: sreq=%b ack=%b want 1 0", S_REQ, m0_ack);
        end
        S_RDY = 1;
        tick();
        n_cmp++;
        if ({m0_ack, m0_err} !== 2'b10 || m0_rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL limit_resp: ack/err=%b rdata=%h want 10 cafef00d", {m0_ack, m0_err}, m0_rdata);
        end
        m0_req = 0; S_RDY = 0;
        tick();
    endtask

    task automatic test_round_robin();
        int seq[3];
        int nack = 0;
        int overlap = 0;
        reset = 0;
        tick();
        m0_req = 1; m0_addr = 32'h10; m0_we = 0;
        m1_req = 1; m1_addr = 32'h20; m1_we = 0;
        S_RDY = 1; O_M = 32'h55;
        reset = 1;
        for (int c = 0; c < 30 && nack < 3; c++) begin
            tick();
            if ((m0_ack && m1_ack) || (S_REQ && (m0_ack || m1_ack))) overlap++;
            if (m0_ack) begin seq[nack] = 0; nack++; end
            else if (m1_ack) begin seq[nack] = 1; nack++; end
        end
        n_cmp++;
        if (nack != 3 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0) begin
            n_fail++; $display("FAIL rr_order: acks=%0d order=%0d,%0d,%0d want 3 acks 0,1,0", nack, seq[0], seq[1], seq[2]);
        end
        n_cmp++;
        if (overlap != 0) begin n_fail++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
        m0_req = 0; m1_req = 0; S_RDY = 0;
        tick();
    endtask

    task automatic test_reset_busy();
        int nack = 0;
        m0_req = 1; m0_addr = 32'h0000_0A00; m0_we = 1; m0_wdata = 32'h1111_2222; m0_be = 4'hF;
        S_RDY = 0;
        tick(); tick();
        reset = 0; m0_req = 0;
        tick();
        n_cmp++;
        if ({S_REQ, busy, m0_ack, m1_ack, E_M, stall} !== 6'b0 || {A_M, D_M, BE_M, m0_rdata, m0_err} !== '0) begin
            n_fail++; $display("FAIL rst_busy_out: flags=%b A_M=%h D_M=%h BE_M=%h r0=%h want all 0", {S_REQ, busy, m0_ack, m1_ack, E_M, stall}, A_M, D_M, BE_M, m0_rdata);
        end
        m0_req = 1; m0_we = 0; m1_req = 1; m1_addr = 32'h0000_0B00; m1_we = 0;
        S_RDY = 1; O_M = 32'h7777_0000;
        reset = 1;
        tick();
        n_cmp++;
        if (A_M !== 32'h0000_0A00 || S_REQ !== 1'b1) begin
            n_fail++; $display("FAIL rst_tie_grant: A_M=%h sreq=%b want 00000a00 1", A_M, S_REQ);
        end
        m1_req = 0;
        tick();
        if (m0_ack) nack++;
        n_cmp++;
        if (nack != 1 || m1_ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_tie_ack: m0_ack=%0d m1_ack=%b want 1 0", nack, m1_ack);
        end
        m0_req = 0; S_RDY = 0;
        tick();
    endtask

    task automatic test_drop_req();
        int nack = 0;
        m0_req = 1; m0_addr = 32'h0000_0C00; m0_we = 0; S_RDY = 0;
        tick();
        m0_req = 0;
        tick();
        n_cmp++;
        if (S_REQ !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL drop_busy: sreq=%b busy=%b want 1 1", S_REQ, busy);
        end
        S_RDY = 1; O_M = 32'h0BAD_F00D;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (m0_ack) begin
                nack++;
                n_cmp++;
                if (m0_rdata !== 32'h0BAD_F00D || m0_err !== 1'b0) begin
                    n_fail++; $display("FAIL drop_rdata: got %h err=%b want 0badf00d 0", m0_rdata, m0_err);
                end
            end
            S_RDY = 0;
        end
        n_cmp++;
        if (nack != 1) begin n_fail++; $display("FAIL drop_ack_count: got %0d want 1", nack); end
    endtask

    initial begin
        test_reset();
        test_m0_load();
        test_m1_store();
        test_timeout();
        test_rdy_at_limit();
        test_round_robin();
        test_reset_busy();
        test_drop_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 15: the number of BUSY cycles without S_RDY before the block aborts with error.
REQ-002 The block SHALL have one clock and synchronous active-low reset, with these ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- m0_req  in  1  CPU MEM-stage request; held with its fields until m0_ack.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  lane-replicated write data.
- m0_be  in  4  byte enables.
- m0_we  in  1  1 = store, 0 = load.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  32  load data, valid while m0_ack=1.
- m0_err  out  1  timeout flag, valid while m0_ack=1.
- m1_req, m1_addr, m1_wdata, m1_be, m1_we, m1_ack, m1_rdata, m1_err  same directions, widths and meanings, for the secondary master (DMA).
- A_M  out  32  bus address.
- D_M  out  32  bus write data.
- BE_M  out  4  bus byte enables.
- E_M  out  1  bus write enable.
- S_REQ  out  1  bus cycle active.
- O_M  in  32  slave read data.
- S_RDY  in  1  slave ready; the write commits and read data is valid in the cycle S_RDY=1.
- stall  out  1  CPU stall = m0_req & ~m0_ack.
- busy  out  1  1 when state is not IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-004 In IDLE with at least one request, the block SHALL grant a master and move to BUSY at the next edge.
REQ-005 On grant, the block SHALL register the granted master's addr, wdata, be and we into A_M, D_M, BE_M and an internal we_q.
REQ-006 On grant, the block SHALL record the granted master as last.
REQ-007 In IDLE with both masters requesting, the block SHALL grant the master not equal to last (round-robin).
REQ-008 In IDLE with only one master requesting, the block SHALL grant that master regardless of last.
REQ-009 In BUSY, S_REQ SHALL be 1, E_M SHALL equal we_q, and A_M, D_M and BE_M SHALL hold stable.
REQ-010 In IDLE and RESP, S_REQ, E_M, A_M, D_M and BE_M SHALL all be 0.
REQ-011 In BUSY, the block SHALL count BUSY cycles in a counter that clears on entry to BUSY and is wide enough for TIMEOUT.
REQ-012 In BUSY with S_RDY=1, the block SHALL capture O_M (when we_q=0; 0 when we_q=1) into the granted master's rdata, clear its err and move to RESP.
REQ-013 In BUSY with S_RDY=0 on the TIMEOUT-th cycle, the block SHALL set rdata=0 and err=1 and move to RESP.
REQ-014 S_RDY=1 on the TIMEOUT-th BUSY cycle SHALL count as success (err=0).
REQ-015 In RESP, only the granted master's ack SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-016 Minimum access latency SHALL be 3 cycles: req sampled at edge T, BUSY during T..T+1, RESP (ack) during T+1..T+2, IDLE after T+2.
REQ-017 The block SHALL not re-arbitrate in RESP; a req held in the ack cycle SHALL be treated as a new request in the following IDLE.
REQ-018 Each rdata/err pair SHALL hold its value until that master's next completion.
REQ-019 A master dropping req during BUSY SHALL not abort the transaction; the transaction SHALL complete and the ack SHALL still be issued.
REQ-020 A request arriving while the other master is served SHALL wait; stall SHALL stay 1 while m0_req=1 and m0_ack=0.
REQ-021 With both masters continuously requesting, grants SHALL alternate m0, m1, m0, ... with no starvation.

Reset
REQ-022 When reset=0 at a rising edge, the block SHALL enter IDLE, set last=m1 so that m0 wins the first tie, clear the counter, and drive all outputs to 0 on the next cycle.
REQ-023 Reset in BUSY or RESP SHALL abort the transaction with no ack, and the slave SHALL see S_REQ=0 from the next cycle.
REQ-024 Reset SHALL override every other event in the same cycle.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- m0 load, addr 0x0000_3004, S_RDY=1 in first BUSY cycle, O_M=0xDEAD_BEEF -> m0_ack one cycle later with m0_rdata=0xDEAD_BEEF, m0_err=0; stall high for 2 cycles.
- m0 and m1 both requesting from reset -> grant order m0, m1, m0; the bus never shows two transactions overlapping.
- m1 store, addr 0x7F10, be=4'b0011, wdata=0x1234_1234, S_RDY after 4 cycles -> E_M=1, BE_M=0011 for 4 BUSY cycles, then m1_ack with m1_err=0.
- S_RDY held 0 with TIMEOUT=15 -> exactly 15 BUSY cycles, then m0_ack=1, m0_err=1, m0_rdata=0.
- reset=0 asserted in the 2nd BUSY cycle -> no ack; all outputs 0 next cycle; the following tie is granted to m0.
- m0_req dropped mid-BUSY -> transaction completes and m0_ack still pulses once.
